// File: rtl/cla_share_seq.sv
// cla_share_seq: two-requester add sequencer sharing one external 4-bit carry-lookahead
// slice. Operands are processed one nibble per cycle, LSB first, with the carry held in a
// register between nibbles. Round-robin grant in front, one valid/ready response behind.
// Optional feature macro: CLA_SEQ_SUB_EN adds per-requester subtract controls.
module cla_share_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req0_cin_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic             req1_cin_i,
`ifdef CLA_SEQ_SUB_EN
    input  logic             req0_sub_i,
    input  logic             req1_sub_i,
`endif
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [WIDTH-1:0] resp_sum_o,
    output logic             resp_co_o,
    output logic [3:0]       slice_a_o,
    output logic [3:0]       slice_b_o,
    output logic             slice_cin_o,
    input  logic [3:0]       slice_sum_i,
    input  logic             slice_co_i
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LsbW = CntW + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              id_q, id_d;
    logic              co_q, co_d;
    logic              rr_q, rr_d;

    logic              gnt0, gnt1, idle;
    logic [LsbW-1:0]   lsb;
    logic [WIDTH-1:0]  b_sel;
    logic              cin_sel;

    // Round-robin grant: a lone requester always wins, a tie goes to the rr_q side.
    always_comb begin
        gnt0         = req0_valid_i && (!req1_valid_i || !rr_q);
        gnt1         = req1_valid_i && (!req0_valid_i || rr_q);
        idle         = (state_q == StIdle) && !rst_i;
        req0_ready_o = idle && gnt0;
        req1_ready_o = idle && gnt1;
        lsb          = {cnt_q, 2'b00};
    end

    // Slice drive: current nibble during RUN, zero otherwise.
    always_comb begin
        slice_a_o   = 4'h0;
        slice_b_o   = 4'h0;
        slice_cin_o = 1'b0;
        if (state_q == StRun) begin
            slice_a_o   = a_q[lsb +: 4];
            slice_b_o   = b_q[lsb +: 4];
            slice_cin_o = carry_q;
        end
        resp_valid_o = (state_q == StDone);
        resp_id_o    = id_q;
        resp_sum_o   = sum_q;
        resp_co_o    = co_q;
    end

    // Operand selection for the granted requester; subtract folds into B and carry-in.
    always_comb begin
        b_sel   = gnt1 ? req1_b_i : req0_b_i;
        cin_sel = gnt1 ? req1_cin_i : req0_cin_i;
`ifdef CLA_SEQ_SUB_EN
        if (gnt1 ? req1_sub_i : req0_sub_i) begin
            b_sel   = ~b_sel;
            cin_sel = 1'b1;
        end
`endif
    end

    // Next-state logic for the sequencer FSM and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        id_d    = id_q;
        co_d    = co_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a_i : req0_a_i;
                    b_d     = b_sel;
                    carry_d = cin_sel;
                    id_d    = gnt1;
                    rr_d    = ~gnt1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[lsb +: 4] = slice_sum_i;
                carry_d         = slice_co_i;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    co_d    = slice_co_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            co_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            co_q    <= co_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_cla_share_seq.sv
// Testbench for cla_share_seq: scoreboard fed on accept, monitor pops on response handshake.
module tb_cla_share_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
`ifdef CLA_SEQ_SUB_EN
    logic             req0_sub, req1_sub;
`endif
    logic             resp_valid, resp_ready, resp_id, resp_co;
    logic [WIDTH-1:0] resp_sum;
    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_cin, slice_co;

    // Hand-computed expected results for whatever each requester currently offers.
    logic [WIDTH-1:0] exp0_sum, exp1_sum;
    logic             exp0_co, exp1_co;

    logic [WIDTH+1:0] sb[$];
    int               checks   = 0;
    int               failures = 0;

    cla_share_seq #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_cin_i   (req0_cin),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_cin_i   (req1_cin),
`ifdef CLA_SEQ_SUB_EN
        .req0_sub_i   (req0_sub),
        .req1_sub_i   (req1_sub),
`endif
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_sum_o   (resp_sum),
        .resp_co_o    (resp_co),
        .slice_a_o    (slice_a),
        .slice_b_o    (slice_b),
        .slice_cin_o  (slice_cin),
        .slice_sum_i  (slice_sum),
        .slice_co_i   (slice_co)
    );

    // External 4-bit adder slice.
    assign {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard feed: push the expected response whenever an accept occurs.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req0_valid && req0_ready) sb.push_back({1'b0, exp0_co, exp0_sum});
                if (req1_valid && req1_ready) sb.push_back({1'b1, exp1_co, exp1_sum});
            end
        end
    end

    // Monitor: compare every response handshake against the oldest expectation.
    initial begin
        logic [WIDTH+1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: got id=%0d sum=0x%0h co=%0d, expected none",
                             resp_id, resp_sum, resp_co);
                end else begin
                    e = sb.pop_front();
                    if ({resp_id, resp_co, resp_sum} !== e) begin
                        failures++;
                        $display("FAIL resp_data: got id=%0d co=%0d sum=0x%0h, expected id=%0d co=%0d sum=0x%0h",
                                 resp_id, resp_co, resp_sum, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait (bounded) for the given requester's grant, then drop its valid after the accept edge.
    task automatic wait_grant(input bit which, input string name);
        int  n     = 0;
        bit  found = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            if ((which ? req1_ready : req0_ready) === 1'b1) found = 1;
            n++;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: got no grant within 40 cycles, expected a grant", name);
        end
        @(posedge clk);
        #1;
        if (which) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || resp_valid !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s: got %0d responses outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic set0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] es, input logic ec);
        req0_a = a; req0_b = b; req0_cin = cin; exp0_sum = es; exp0_co = ec;
    endtask

    task automatic set1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] es, input logic ec);
        req1_a = a; req1_b = b; req1_cin = cin; exp1_sum = es; exp1_co = ec;
    endtask

    initial begin
        int         lat;
        bit         found;
        bit         held;
        bit         quiet;
        logic [3:0] cin_seen;
        logic [8:0] s0;

        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set0('0, '0, 1'b0, '0, 1'b0);
        set1('0, '0, 1'b0, '0, 1'b0);
`ifdef CLA_SEQ_SUB_EN
        req0_sub = 1'b0; req1_sub = 1'b0;
`endif
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_resp", {resp_valid, resp_id, resp_co, resp_sum}, 32'h0);
        check("rst_ready", {req0_ready, req1_ready}, 32'h0);
        check("rst_slice", {slice_a, slice_b, slice_cin}, 32'h0);

        // 1: 0x1234 + 0x4321, latency N and first-nibble slice drive.
        @(posedge clk); #1;
        set0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        req0_valid = 1'b1;
        wait_grant(1'b0, "t1_grant");
        lat = 0; found = 0; s0 = '0;
        while (!found && lat < 20) begin
            @(negedge clk);
            if (lat == 0 && !found) s0 = {slice_a, slice_b, slice_cin};
            if (resp_valid) found = 1;
            else lat++;
        end
        check("t1_latency", lat, 4);
        check("t1_slice_k0", s0, {4'h4, 4'h1, 1'b0});
        wait_idle("t1_drain");

        // 2: 0xFFFF + 1 from requester 1; carry ripples through every nibble.
        @(posedge clk); #1;
        set1(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        req1_valid = 1'b1;
        wait_grant(1'b1, "t2_grant");
        cin_seen = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cin_seen[k] = slice_cin;
        end
        check("t2_ripple", cin_seen, 4'b1110);
        wait_idle("t2_drain");

        // 3: both valid from reset, held; req0 first, then req1, then req0 again.
        do_reset();
        set0(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);
        set1(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("t3_first_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(1'b1, "t3_second_grant");
        wait_idle("t3_drain_a");
        @(posedge clk); #1;
        set0(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        set1(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("t3_alternate", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(1'b1, "t3_alt_second");
        wait_idle("t3_drain_b");

        // 4: response back-pressured for 10 cycles.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set0(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        req0_valid = 1'b1;
        wait_grant(1'b0, "t4_grant");
        set1(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0);
        req1_valid = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 20) begin
            @(negedge clk);
            if (resp_valid) found = 1;
            else lat++;
        end
        check("t4_valid_seen", found, 1);
        held = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ({resp_valid, resp_id, resp_co, resp_sum, req0_ready, req1_ready}
                !== {1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}) held = 0;
        end
        check("t4_hold", held, 1);
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_back_idle", {resp_valid, req1_ready}, 2'b01);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_idle("t4_drain");

        // 5: reset during RUN k=2; aborted op never responds, rr returns to req0.
        @(posedge clk); #1;
        set0(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        req0_valid = 1'b1;
        wait_grant(1'b0, "t5_grant");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        quiet = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) quiet = 0;
        end
        check("t5_no_resp", quiet, 1);
        @(posedge clk); #1;
        set0(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);
        set1(16'h7000, 16'h9000, 1'b0, 16'h0000, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("t5_rr_reset", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(1'b1, "t5_second_grant");
        wait_idle("t5_drain");

`ifdef CLA_SEQ_SUB_EN
        // 6: subtract; cin ignored, co=1 means no borrow.
        @(posedge clk); #1;
        set0(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        req0_sub = 1'b1;
        req0_valid = 1'b1;
        wait_grant(1'b0, "t6_grant_a");
        req0_sub = 1'b0;
        wait_idle("t6_drain_a");
        @(posedge clk); #1;
        set1(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        req1_sub = 1'b1;
        req1_valid = 1'b1;
        wait_grant(1'b1, "t6_grant_b");
        req1_sub = 1'b0;
        wait_idle("t6_drain_b");
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
